// File: rtl/rf_wb_arb.sv
// rtl/rf_wb_arb.sv - register-file writeback arbiter: pipeline writes win, long-latency results queue in a 2-entry FIFO
// Optional feature: define RF_WB_BYPASS_EN to route lsu results straight to the write port when nothing is queued.

module rf_wb_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wd,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_wd,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  output logic [31:0] pending,
  output logic        stall_req
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  logic [4:0]    q_rd [2];
  logic [31:0]   q_wd [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [CW-1:0] starve;

  logic accept;
  logic lsu_keep;
  logic bypass;
  logic enq;
  logic deq;

  assign lsu_ready = ~reset & (count != 2'd2);
  assign accept    = lsu_valid & lsu_ready;
  // Writes to x0 are swallowed here so they never occupy a slot or the write port.
  assign lsu_keep  = accept & (lsu_rd != 5'd0);

`ifdef RF_WB_BYPASS_EN
  assign bypass = lsu_keep & (count == 2'd0) & ~pipe_we;
`else
  assign bypass = 1'b0;
`endif

  assign enq = lsu_keep & ~bypass;
  assign deq = (count != 2'd0) & ~pipe_we;

  assign stall_req = (starve == STARVE_MAX) || (count == 2'd2);

  always_comb begin
    pending = '0;
    for (int i = 0; i < 2; i++) begin
      if ((i[0] == rd_ptr) ? (count != 2'd0) : (count == 2'd2)) begin
        pending[q_rd[i]] = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

  // Queue storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_rd[wr_ptr] <= lsu_rd;
      q_wd[wr_ptr] <= lsu_wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      starve <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, enq} - {1'b0, deq};
      if ((count == 2'd0) || deq) begin
        starve <= '0;
      end else if (starve != STARVE_MAX) begin
        starve <= starve + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3 <= 1'b0;
      a3  <= 5'd0;
      wd3 <= 32'd0;
    end else if (pipe_we) begin
      we3 <= (pipe_rd != 5'd0);
      if (pipe_rd != 5'd0) begin
        a3  <= pipe_rd;
        wd3 <= pipe_wd;
      end
    end else if (deq) begin
      we3 <= 1'b1;
      a3  <= q_rd[rd_ptr];
      wd3 <= q_wd[rd_ptr];
    end else if (bypass) begin
      we3 <= 1'b1;
      a3  <= lsu_rd;
      wd3 <= lsu_wd;
    end else begin
      we3 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wb_arb.sv
// tb/tb_rf_wb_arb.sv - directed scoreboard bench for rf_wb_arb

module tb_rf_wb_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_wd = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_wd = '0;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] pending;
  logic        stall_req;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wd;
  } wr_t;

  wr_t q[$];
  wr_t e;
  int  checks = 0;
  int  errors = 0;

  rf_wb_arb #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
    .we3(we3), .a3(a3), .wd3(wd3), .pending(pending), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe_w(input logic [4:0] rd, input logic [31:0] wd);
    pipe_we = 1'b1;
    pipe_rd = rd;
    pipe_wd = wd;
    q.push_back('{rd: rd, wd: wd});
  endtask

  always @(negedge clk) begin
    if (we3 === 1'b1) begin
      chk("sb_expected_write", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_a3", 32'(a3), 32'(e.rd));
        chk("sb_wd3", wd3, e.wd);
      end
    end
  end

  initial begin
    tick();
    tick();
    chk("rst_we3", 32'(we3), 0);
    chk("rst_pending", pending, 0);
    chk("rst_stall", 32'(stall_req), 0);
    chk("rst_lsu_ready", 32'(lsu_ready), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(lsu_ready), 1);

    // pipe only
    pipe_w(5'd5, 32'h1234);
    tick();
    pipe_we = 1'b0;
    chk("pipe_we3", 32'(we3), 1);
    chk("pipe_a3", 32'(a3), 5);
    chk("pipe_wd3", wd3, 32'h1234);
    chk("pipe_pending", pending, 0);
    tick();
    chk("idle_we3", 32'(we3), 0);
    chk("idle_a3_hold", 32'(a3), 5);

    // lsu only
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_wd = 32'hDEAD;
    chk("lsu_ready_empty", 32'(lsu_ready), 1);
    q.push_back('{rd: 5'd9, wd: 32'hDEAD});
    tick();
    lsu_valid = 1'b0;
`ifdef RF_WB_BYPASS_EN
    chk("byp_we3", 32'(we3), 1);
    chk("byp_a3", 32'(a3), 9);
    chk("byp_pending", pending, 0);
`else
    chk("lsu_pending9", pending, 32'h1 << 9);
    chk("lsu_we3_n1", 32'(we3), 0);
    tick();
    chk("lsu_we3_n2", 32'(we3), 1);
    chk("lsu_a3_n2", 32'(a3), 9);
    chk("lsu_wd3_n2", wd3, 32'hDEAD);
    chk("lsu_pending_n2", pending, 0);
`endif
    tick();

    // collision
    pipe_w(5'd4, 32'h44);
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_wd = 32'h66;
    q.push_back('{rd: 5'd6, wd: 32'h66});
    tick();
    pipe_we = 1'b0; lsu_valid = 1'b0;
    chk("col_a3_pipe", 32'(a3), 4);
    chk("col_pending6", pending, 32'h1 << 6);
    tick();
    chk("col_we3_lsu", 32'(we3), 1);
    chk("col_a3_lsu", 32'(a3), 6);
    chk("col_pending0", pending, 0);
    tick();

    // starvation
    pipe_w(5'd1, 32'h101);
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_wd = 32'hA0;
    tick();
    pipe_w(5'd2, 32'h102);
    lsu_rd = 5'd11; lsu_wd = 32'hB0;
    chk("stv_ready_one", 32'(lsu_ready), 1);
    tick();
    lsu_valid = 1'b0;
    chk("stv_full_ready", 32'(lsu_ready), 0);
    chk("stv_full_stall", 32'(stall_req), 1);
    chk("stv_full_pending", pending, (32'h1 << 10) | (32'h1 << 11));
    lsu_valid = 1'b1; lsu_rd = 5'd15; lsu_wd = 32'hF0;
    for (int i = 0; i < 5; i++) begin
      pipe_w(5'(3 + i), 32'h103 + i);
      tick();
    end
    lsu_valid = 1'b0;
    chk("stv_sat_stall", 32'(stall_req), 1);
    chk("stv_no_enq_full", pending, (32'h1 << 10) | (32'h1 << 11));
    pipe_we = 1'b0;
    q.push_back('{rd: 5'd10, wd: 32'hA0});
    tick();
    chk("stv_drain_a3", 32'(a3), 10);
    chk("stv_drain_pending", pending, 32'h1 << 11);
    chk("stv_drain_ready", 32'(lsu_ready), 1);
    chk("stv_drain_stall", 32'(stall_req), 0);
    for (int i = 0; i < 3; i++) begin
      pipe_w(5'(20 + i), 32'h200 + i);
      tick();
    end
    chk("stv_cnt3_stall", 32'(stall_req), 0);
    pipe_w(5'd23, 32'h203);
    tick();
    chk("stv_cnt4_stall", 32'(stall_req), 1);
    pipe_we = 1'b0;
    q.push_back('{rd: 5'd11, wd: 32'hB0});
    tick();
    chk("stv_drain2_a3", 32'(a3), 11);
    chk("stv_drain2_pending", pending, 0);
    chk("stv_drain2_stall", 32'(stall_req), 0);
    tick();

    // x0 drops
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_wd = 32'hBAD;
    chk("x0_ready", 32'(lsu_ready), 1);
    tick();
    lsu_valid = 1'b0;
    chk("x0_pending", pending, 0);
    chk("x0_we3_a", 32'(we3), 0);
    tick();
    chk("x0_we3_b", 32'(we3), 0);
    pipe_we = 1'b1; pipe_rd = 5'd0; pipe_wd = 32'hBAD;
    tick();
    pipe_we = 1'b0;
    chk("x0_pipe_we3", 32'(we3), 0);
    chk("x0_pipe_a3_hold", 32'(a3), 11);

    // reset with two queued entries
    pipe_w(5'd1, 32'h301);
    lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_wd = 32'hD0;
    tick();
    pipe_w(5'd2, 32'h302);
    lsu_rd = 5'd14; lsu_wd = 32'hE0;
    tick();
    lsu_valid = 1'b0;
    chk("mid_pending", pending, (32'h1 << 13) | (32'h1 << 14));
    pipe_rd = 5'd0; pipe_wd = 32'h0;
    tick();
    reset = 1'b1;
    pipe_we = 1'b0;
    #1;
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_we3", 32'(we3), 0);
    chk("mid_rst_a3", 32'(a3), 0);
    chk("mid_rst_wd3", wd3, 0);
    chk("mid_rst_stall", 32'(stall_req), 0);
    chk("mid_rst_ready", 32'(lsu_ready), 0);
    tick();
    tick();
    reset = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'h77;
    q.push_back('{rd: 5'd7, wd: 32'h77});
    #1;
    chk("first_edge_ready", 32'(lsu_ready), 1);
    tick();
    lsu_valid = 1'b0;
`ifdef RF_WB_BYPASS_EN
    chk("first_edge_we3", 32'(we3), 1);
    chk("first_edge_a3", 32'(a3), 7);
`else
    chk("first_edge_pending", pending, 32'h1 << 7);
    tick();
    chk("first_edge_we3", 32'(we3), 1);
    chk("first_edge_a3", 32'(a3), 7);
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    chk("post_pending", pending, 0);
    chk("sb_drained", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arb.md
RF_WB_ARB -- requirements
Module: rf_wb_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, max cycles a non-empty queue waits before stall_req is forced.
REQ-002 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pipe_we  input  1  pipeline writeback valid; never back-pressured.
REQ-005 SHALL have port pipe_rd  input  5  pipeline destination register.
REQ-006 SHALL have port pipe_wd  input  32  pipeline writeback data.
REQ-007 SHALL have port lsu_valid  input  1  long-latency unit result valid.
REQ-008 SHALL have port lsu_ready  output  1  queue can accept; lsu_valid&&lsu_ready = accept.
REQ-009 SHALL have port lsu_rd  input  5  long-latency destination register.
REQ-010 SHALL have port lsu_wd  input  32  long-latency result data.
REQ-011 SHALL have port we3  output  1  registered write enable to register file.
REQ-012 SHALL have port a3  output  5  registered write address to register file.
REQ-013 SHALL have port wd3  output  32  registered write data to register file.
REQ-014 SHALL have port pending  output  32  bit r set while a queued write targets xr.
REQ-015 SHALL have port stall_req  output  1  request to hold pipeline writeback for one cycle.

Function
REQ-016 SHALL hold a 2-entry in-order FIFO of {rd, data} for accepted lsu writes.
REQ-017 SHALL drive lsu_ready = 1 when FIFO count < 2 and reset deasserted, else 0; no enqueue when full, even if a dequeue occurs that cycle.
REQ-018 SHALL give pipe_we absolute priority: pipe_we at cycle N -> we3=1, a3=pipe_rd, wd3=pipe_wd at cycle N+1.
REQ-019 SHALL dequeue the FIFO head only in a cycle with pipe_we=0; head written at next cycle (enqueue N -> earliest we3 at N+2).
REQ-020 SHALL drive we3=0 in the cycle after a cycle with neither a pipe write nor a dequeue; a3/wd3 hold their last values.
REQ-021 SHALL drop writes with rd=0 from either source: never enqueued, never produce we3=1; a dropped lsu handshake still completes.
REQ-022 SHALL compute pending combinationally as OR over valid FIFO entries of one-hot(rd); bit 0 always 0.
REQ-023 SHALL keep a starvation counter: increments each cycle FIFO non-empty and no dequeue, clears on dequeue or FIFO empty, saturates at STARVE_LIMIT.
REQ-024 SHALL assert stall_req combinationally when counter == STARVE_LIMIT or FIFO count == 2.
REQ-025 SHALL NOT reorder writes; WAW ordering between sources is enforced upstream via pending.
REQ-026 SHALL, on simultaneous pipe_we and lsu accept, write pipe data and enqueue lsu data in the same cycle.
REQ-027 SHALL treat pipe_we asserted while stall_req=1 as legal; pipe still wins, counter keeps saturating.

Reset
REQ-028 SHALL, on reset assertion, immediately clear we3, a3, wd3, FIFO count/pointers, starvation counter; pending=0, stall_req=0, lsu_ready=0.
REQ-029 SHALL, on reset mid-operation, discard all queued entries without writing them.
REQ-030 SHALL accept lsu handshakes from the first rising edge after reset deasserts.

Configuration
REQ-031 SHALL, with RF_WB_BYPASS_EN defined, route an lsu accept straight to the write port when FIFO is empty and pipe_we=0 (accept N -> we3 at N+1), leaving FIFO and pending unchanged.
REQ-032 SHALL, without RF_WB_BYPASS_EN, always enqueue accepted lsu writes (latency N+2 minimum).

Verification
REQ-033 Pipe only: pipe_we=1, rd=5, wd=0x1234 at N -> we3=1, a3=5, wd3=0x1234 at N+1, pending=0.
REQ-034 LSU only, bypass off: accept rd=9, wd=0xDEAD at N -> pending[9]=1 at N+1, we3 write to x9 at N+2, pending=0 at N+2.
REQ-035 Collision: pipe rd=4 and lsu rd=6 both at N, pipe idle after -> x4 written N+1, x6 written N+2.
REQ-036 Starvation: two lsu accepts then pipe_we=1 every cycle -> lsu_ready=0 and stall_req=1 once full; releasing pipe_we one cycle drains one entry.
REQ-037 x0 and reset: lsu rd=0 accepted -> no we3, pending=0; reset with 2 queued entries -> pending=0, no writes after release.
REQ-038 Bypass on: empty FIFO, lsu accept rd=3, wd=0x55 at N, pipe idle -> we3 to x3 at N+1, pending stays 0.
